// File: rtl/chord_pkg.sv
// ============================================================================
// Module      : chord_pkg
// Description : Shared types, default timing constants and a seconds-to-cycles
//               helper for the chord press detector.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package chord_pkg;

    // Chord tracking states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HOLD = 2'd1,
        ST_LONG = 2'd2
    } chord_state_e;

    localparam int DEF_N_CH          = 2;
    localparam int DEF_CLK_HZ        = 50_000_000;
    localparam int DEF_LONG_SEC      = 3;
    localparam int DEF_SHORT_MIN_CYC = 2_500_000;
    localparam int DEF_DEBOUNCE_CYC  = 500_000;
    localparam int DEF_REPEAT_CYC    = 12_500_000;

    // Convert a hold time in seconds into clock cycles
    function automatic int sec_to_cyc(input int sec, input int clk_hz);
        return sec * clk_hz;
    endfunction

endpackage

`default_nettype wire

// File: rtl/btn_debounce.sv
// ============================================================================
// Module      : btn_debounce
// Description : One button channel: 2-FF synchroniser followed by a stability
//               counter. The debounced level follows the synchronised level
//               once it has differed for DEBOUNCE_CYC consecutive cycles.
//               DEBOUNCE_CYC = 0 passes the synchroniser output straight out.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module btn_debounce
    import chord_pkg::*;
#(
    parameter int DEBOUNCE_CYC = DEF_DEBOUNCE_CYC
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic db_out
);

    logic sync1_q, sync1_d;
    logic sync2_q, sync2_d;

    // Synchroniser stage inputs
    always_comb begin
        sync1_d = btn_raw;
        sync2_d = sync1_q;
    end

    // Two-flop synchroniser against metastability on the raw button level
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
        end
    end

    generate
        if (DEBOUNCE_CYC == 0) begin : g_bypass
            assign db_out = sync2_q;
        end else begin : g_filter
            localparam int CNT_W = (DEBOUNCE_CYC < 2) ? 1 : $clog2(DEBOUNCE_CYC + 1);
            localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);

            logic [CNT_W-1:0] cnt_q, cnt_d;
            logic             db_q, db_d;

            // Count while the synchronised level disagrees; commit on the last count
            always_comb begin
                cnt_d = '0;
                db_d  = db_q;
                if (sync2_q != db_q) begin
                    if (cnt_q == CNT_LAST) begin
                        db_d = sync2_q;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end

            // Debounce counter and debounced level registers
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    cnt_q <= '0;
                    db_q  <= 1'b0;
                end else begin
                    cnt_q <= cnt_d;
                    db_q  <= db_d;
                end
            end

            assign db_out = db_q;
        end
    endgenerate

endmodule

`default_nettype wire

// File: rtl/chord_press_detector.sv
// ============================================================================
// Module      : chord_press_detector
// Description : Debounces N_CH buttons and classifies releases of a selectable
//               chord as short or long presses with single-cycle pulses.
//               Optional auto-repeat while held long: define CHORD_REPEAT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module chord_press_detector
    import chord_pkg::*;
#(
    parameter int N_CH          = DEF_N_CH,
    parameter int CLK_HZ        = DEF_CLK_HZ,
    parameter int LONG_SEC      = DEF_LONG_SEC,
    parameter int SHORT_MIN_CYC = DEF_SHORT_MIN_CYC,
    parameter int DEBOUNCE_CYC  = DEF_DEBOUNCE_CYC,
    parameter int REPEAT_CYC    = DEF_REPEAT_CYC
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N_CH-1:0] btn,
    input  logic [N_CH-1:0] chord_mask,
    input  logic            cancel,
    output logic            short_pulse,
    output logic            long_pulse,
    output logic            repeat_pulse,
    output logic            hold_active,
    output logic [N_CH-1:0] db_state
);

    localparam int LONG_CYC = sec_to_cyc(LONG_SEC, CLK_HZ);
    localparam int TIMER_W  = $clog2(LONG_CYC + 1);
    localparam logic [TIMER_W-1:0] LONG_LAST = TIMER_W'(LONG_CYC - 1);
    localparam logic [TIMER_W-1:0] LONG_MAX  = TIMER_W'(LONG_CYC);
    localparam logic [TIMER_W-1:0] SHORT_MIN = TIMER_W'(SHORT_MIN_CYC);

    logic [N_CH-1:0] db_w;

    generate
        for (genvar i = 0; i < N_CH; i++) begin : g_ch
            btn_debounce #(
                .DEBOUNCE_CYC (DEBOUNCE_CYC)
            ) u_debounce (
                .clk     (clk),
                .rst     (rst),
                .btn_raw (btn[i]),
                .db_out  (db_w[i])
            );
        end
    endgenerate

    assign db_state = db_w;

    chord_state_e     state_q, state_d;
    logic [N_CH-1:0]  mask_q, mask_d;
    logic [TIMER_W-1:0] timer_q, timer_d;
    logic             armed_q, armed_d;
    logic             hold_q, hold_d;
    logic             short_q, short_d;
    logic             long_q, long_d;
    logic             ok_held;
    logic             ok_new;

    // Chord satisfied against the latched mask (tracking) or the live mask (idle)
    always_comb begin
        ok_held = (mask_q != '0) && ((db_w & mask_q) == mask_q);
        ok_new  = (chord_mask != '0) && ((db_w & chord_mask) == chord_mask);
    end

    // Next-state, timer and pulse decisions; cancel overrides everything
    always_comb begin
        state_d = state_q;
        mask_d  = mask_q;
        timer_d = timer_q;
        armed_d = armed_q;
        hold_d  = hold_q;
        short_d = 1'b0;
        long_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                mask_d  = chord_mask;
                timer_d = '0;
                // Re-arm only once the chord has been seen released
                armed_d = armed_q | ~ok_new;
                if (armed_q && ok_new) begin
                    state_d = ST_HOLD;
                    timer_d = TIMER_W'(1);
                end
            end
            ST_HOLD: begin
                if (!ok_held) begin
                    short_d = (timer_q >= SHORT_MIN);
                    state_d = ST_IDLE;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + TIMER_W'(1);
                    if (timer_q == LONG_LAST) begin
                        state_d = ST_LONG;
                        hold_d  = 1'b1;
                    end
                end
            end
            ST_LONG: begin
                if (!ok_held) begin
                    long_d  = 1'b1;
                    hold_d  = 1'b0;
                    state_d = ST_IDLE;
                    timer_d = '0;
                end else if (timer_q != LONG_MAX) begin
                    timer_d = timer_q + TIMER_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                timer_d = '0;
                hold_d  = 1'b0;
            end
        endcase

        if (cancel) begin
            state_d = ST_IDLE;
            timer_d = '0;
            armed_d = 1'b0;
            hold_d  = 1'b0;
            short_d = 1'b0;
            long_d  = 1'b0;
        end
    end

    // FSM, mask latch, timer and registered pulse outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            mask_q  <= '0;
            timer_q <= '0;
            armed_q <= 1'b0;
            hold_q  <= 1'b0;
            short_q <= 1'b0;
            long_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mask_q  <= mask_d;
            timer_q <= timer_d;
            armed_q <= armed_d;
            hold_q  <= hold_d;
            short_q <= short_d;
            long_q  <= long_d;
        end
    end

    assign short_pulse = short_q;
    assign long_pulse  = long_q;
    assign hold_active = hold_q;

`ifdef CHORD_REPEAT_EN
    localparam int REP_W = (REPEAT_CYC < 2) ? 1 : $clog2(REPEAT_CYC + 1);
    localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_CYC - 1);

    logic [REP_W-1:0] rep_cnt_q, rep_cnt_d;
    logic             repeat_q, repeat_d;

    // Fire on entry to LONG, then once per REPEAT_CYC while staying in LONG
    always_comb begin
        rep_cnt_d = '0;
        repeat_d  = 1'b0;
        if ((state_q != ST_LONG) && (state_d == ST_LONG)) begin
            repeat_d = 1'b1;
        end else if ((state_q == ST_LONG) && (state_d == ST_LONG)) begin
            if (rep_cnt_q == REP_LAST) begin
                repeat_d = 1'b1;
            end else begin
                rep_cnt_d = rep_cnt_q + REP_W'(1);
            end
        end
    end

    // Repeat counter and pulse register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rep_cnt_q <= '0;
            repeat_q  <= 1'b0;
        end else begin
            rep_cnt_q <= rep_cnt_d;
            repeat_q  <= repeat_d;
        end
    end

    assign repeat_pulse = repeat_q;
`else
    assign repeat_pulse = 1'b0;
`endif

endmodule

`default_nettype wire
